// File: rtl/modulo_4.sv
// Two-bit modulo-4 up/down counter as a four-state Moore FSM.
// Mode {D1,D2}: 00 hold, 01 increment, 10 decrement, 11 step by two.
module modulo_4 (
  input  logic CLK1,
  input  logic RST,
  input  logic D1,
  input  logic D2,
  output logic f,
  output logic g
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] mode_s;

  assign mode_s = {D1, D2};

  // Next-state decode: full transition table, fallback returns to S0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: begin
        case (mode_s)
          2'b00:   state_d = S0;
          2'b01:   state_d = S1;
          2'b10:   state_d = S3;
          2'b11:   state_d = S2;
          default: state_d = S0;
        endcase
      end
      S1: begin
        case (mode_s)
          2'b00:   state_d = S1;
          2'b01:   state_d = S2;
          2'b10:   state_d = S0;
          2'b11:   state_d = S3;
          default: state_d = S0;
        endcase
      end
      S2: begin
        case (mode_s)
          2'b00:   state_d = S2;
          2'b01:   state_d = S3;
          2'b10:   state_d = S1;
          2'b11:   state_d = S0;
          default: state_d = S0;
        endcase
      end
      S3: begin
        case (mode_s)
          2'b00:   state_d = S3;
          2'b01:   state_d = S0;
          2'b10:   state_d = S2;
          2'b11:   state_d = S1;
          default: state_d = S0;
        endcase
      end
      default: state_d = S0;
    endcase
  end

  // State register with synchronous reset taking priority over the mode.
  always_ff @(posedge CLK1) begin
    if (RST) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign f = state_q[1];
  assign g = state_q[0];

endmodule

// File: tb/tb_modulo_4.sv
// Self-checking bench for modulo_4: expected fg values are queued as stimulus is
// applied and popped for comparison one time unit after the following rising edge.
module tb_modulo_4;

  logic CLK1;
  logic RST;
  logic D1;
  logic D2;
  logic f;
  logic g;

  logic [1:0] sb[$];
  logic [1:0] model_q;
  int         n_checks;
  int         n_fail;

  modulo_4 dut (
    .CLK1(CLK1),
    .RST (RST),
    .D1  (D1),
    .D2  (D2),
    .f   (f),
    .g   (g)
  );

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  // Drive inputs on the falling edge, queue the expected result, step one edge.
  task automatic apply(input logic rst, input logic [1:0] mode, input logic [1:0] exp);
    @(negedge CLK1);
    RST = rst;
    D1  = mode[1];
    D2  = mode[0];
    sb.push_back(exp);
    model_q = exp;
    @(posedge CLK1);
    #1;
  endtask

  // Independent reference: arithmetic modulo 4, not a transition table.
  function automatic logic [1:0] model_next(input logic rst, input logic [1:0] mode,
                                            input logic [1:0] q);
    logic [2:0] sum;
    if (rst) return 2'd0;
    case (mode)
      2'b01:   sum = {1'b0, q} + 3'd1;
      2'b10:   sum = {1'b0, q} + 3'd3;
      2'b11:   sum = {1'b0, q} + 3'd2;
      default: sum = {1'b0, q};
    endcase
    return sum[1:0];
  endfunction

  task automatic test_reset();
    logic [1:0] exp;
    apply(1'b1, 2'b00, 2'b00);
    exp = sb.pop_front();
    n_checks++;
    if ({f, g} !== exp) begin
      n_fail++;
      $display("FAIL reset_first: fg=%b expected=%b", {f, g}, exp);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'b01, 2'b00);
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL reset_held[%0d]: fg=%b expected=%b", i, {f, g}, exp);
      end
    end
  endtask

  task automatic test_hold_inc();
    logic [1:0] modes[4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic [1:0] exps[4]  = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, modes[i], exps[i]);
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL hold_inc[%0d]: fg=%b expected=%b", i, {f, g}, exp);
      end
    end
  endtask

  task automatic test_decrement();
    logic [1:0] exps[4] = '{2'b01, 2'b00, 2'b11, 2'b10};
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 2'b10, exps[i]);
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL decrement[%0d]: fg=%b expected=%b", i, {f, g}, exp);
      end
    end
  endtask

  task automatic test_step_two();
    logic [1:0] modes[5] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11};
    logic [1:0] exps[5]  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0] exp;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, modes[i], exps[i]);
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL step_two[%0d]: fg=%b expected=%b", i, {f, g}, exp);
      end
    end
  endtask

  task automatic test_inc_wrap();
    logic [1:0] exps[6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [1:0] exp;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 2'b01, exps[i]);
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL inc_wrap[%0d]: fg=%b expected=%b", i, {f, g}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       rsts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] exps[4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      apply(rsts[i], 2'b01, exps[i]);
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: fg=%b expected=%b", i, {f, g}, exp);
      end
    end
  endtask

  task automatic test_between_edges();
    logic [1:0] exp;
    D1 = 1'b1;
    D2 = 1'b1;
    #2;
    D1 = 1'b1;
    D2 = 1'b0;
    apply(1'b0, 2'b00, model_q);
    exp = sb.pop_front();
    n_checks++;
    if ({f, g} !== exp) begin
      n_fail++;
      $display("FAIL between_edges: fg=%b expected=%b", {f, g}, exp);
    end
  endtask

  task automatic test_random();
    logic       rst;
    logic [1:0] mode;
    logic [1:0] exp;
    for (int i = 0; i < 60; i++) begin
      rst  = ($urandom_range(0, 15) == 0);
      mode = 2'($urandom_range(0, 3));
      apply(rst, mode, model_next(rst, mode, model_q));
      exp = sb.pop_front();
      n_checks++;
      if ({f, g} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: rst=%b mode=%b fg=%b expected=%b", i, rst, mode, {f, g}, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_q  = 2'b00;
    RST      = 1'b1;
    D1       = 1'b0;
    D2       = 1'b0;
    test_reset();
    test_hold_inc();
    test_decrement();
    test_step_two();
    test_inc_wrap();
    test_reset_mid();
    test_between_edges();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modulo_4.md
Name: modulo_4

Overview:
- Two-bit modulo-4 up/down counter implemented as a four-state Moore FSM.
- Mode inputs D1/D2 select hold, increment, decrement or step-by-two each clock.
- The state is presented directly on the two registered outputs f (MSB) and g (LSB).
- Small control/sequencing block driven by a single clock CLK1 with a synchronous active-high reset RST.

Parameters:
- None. State width is fixed at 2 bits and the modulus is fixed at 4.

Ports:
- CLK1  input  1  Clock. All state updates occur on the rising edge.
- RST  input  1  Reset, synchronous and active-high. Sampled on the CLK1 rising edge.
- D1  input  1  Mode select bit, MSB.
- D2  input  1  Mode select bit, LSB.
- f  output  1  State bit 1 (MSB). Registered.
- g  output  1  State bit 0 (LSB). Registered.

Behaviour:
- Single clock: CLK1. Reset is synchronous and active-high (RST). There is no asynchronous path.
- State register Q[1:0] holds one of four states:
  - S0 = 00
  - S1 = 01
  - S2 = 10
  - S3 = 11
- Outputs: f = Q[1], g = Q[0]. Both come straight from flops with no combinational logic from D1/D2 (Moore machine).
- Reset:
  - If RST = 1 at a CLK1 rising edge, Q becomes 00, so f = 0 and g = 0 after that edge.
  - RST has priority over D1/D2.
  - If RST stays high, Q stays 00 every cycle.
  - Asserting RST mid-count returns Q to 00 at the next rising edge.
- Before the first reset edge, the outputs are undefined. The bench must not check them.
- Mode {D1,D2}, sampled at the CLK1 rising edge when RST = 0:
  - 00: hold. Q_next = Q.
  - 01: increment. Q_next = (Q + 1) mod 4.
  - 10: decrement. Q_next = (Q − 1) mod 4.
  - 11: step two. Q_next = (Q + 2) mod 4.
- Wrap-around:
  - Increment: 11 → 00.
  - Decrement: 00 → 11.
  - Step two: 10 → 00 and 11 → 01.
  - Wrap is silent; there is no carry or borrow output.
- Latency:
  - An input change takes effect at the first rising edge at which it is sampled.
  - The outputs reflect the new state immediately after that edge (1-cycle latency).
- D1 and D2 must be stable around the rising edge. Changes between edges have no effect.
- Full transition table (current state → next state for modes 00/01/10/11):
  - S0 → S0 / S1 / S3 / S2
  - S1 → S1 / S2 / S0 / S3
  - S2 → S2 / S3 / S1 / S0
  - S3 → S3 / S0 / S2 / S1
- Implementation structure:
  - Explicit next-state combinational block with a default assignment. No latches.
  - Separate sequential block for the state flops.

Test Plan:
- Reset: RST = 1 for ≥1 rising edge, D1D2 = 00 → fg = 00. Hold RST = 1 for 4 edges with D1D2 = 01 → fg stays 00.
- Hold: from 00 after reset, RST = 0, D1D2 = 00 for 2 edges → fg = 00, 00. Then D1D2 = 01 for 2 edges → fg = 01, 10.
- Decrement and wrap: from fg = 10, D1D2 = 10 for 4 edges → fg = 01, 00, 11, 10.
- Step two: from fg = 10, D1D2 = 11 for 3 edges → fg = 00, 10, 00. From fg = 01, D1D2 = 11 for 1 edge → fg = 11.
- Increment wrap: from 00, D1D2 = 01 for 5 edges → fg = 01, 10, 11, 00, 01.
- Reset mid-operation: while counting with D1D2 = 01 at fg = 11, assert RST = 1 for 1 edge → fg = 00. Deassert RST → the next edge gives fg = 01.
